// File: rtl/systolic_mm.sv
// Weight-stationary K x K systolic array computing y[j] = sum_i x[i]*W[i][j].
// Inputs are skewed per row and outputs de-skewed per column so a whole vector leaves together.
module systolic_mm #(
  parameter int K  = 4,
  parameter int DW = 8,
  parameter int AW = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [K*K*DW-1:0] w_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [K*DW-1:0]   in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [K*AW-1:0]   out_data,
  output logic              out_last,
  output logic              busy
);
  localparam int PW = 2 * DW;

  typedef enum logic [1:0] {StIdle, StLoad, StStream, StDrain} state_e;
  state_e state_q, state_d;

  logic                 adv;
  logic                 accept;
  logic [2*K:0]         vld_q;
  logic [2*K:0]         lst_q;
  logic signed [DW-1:0] w_q   [K][K];
  logic signed [DW-1:0] sk_q  [K][K];
  logic signed [DW-1:0] a_q   [K][K];
  logic signed [DW-1:0] a_in  [K][K];
  logic signed [PW-1:0] prod  [K][K];
  logic signed [AW-1:0] p_q   [K][K];
  logic signed [AW-1:0] p_d   [K][K];
  logic signed [AW-1:0] dsk_q [K][K];

  // A stalled output freezes the entire pipeline, including the skew and valid chains.
  assign out_valid = vld_q[2*K];
  assign out_last  = lst_q[2*K];
  assign adv       = !(out_valid && !out_ready);
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q != StIdle);

  always_comb begin
    state_d  = state_q;
    w_ready  = 1'b0;
    in_ready = 1'b0;
    unique case (state_q)
      StIdle: begin
        w_ready = 1'b1;
        if (w_valid) state_d = StLoad;
      end
      StLoad: state_d = StStream;
      StStream: begin
        in_ready = adv;
        if (in_valid && adv && in_last) state_d = StDrain;
      end
      StDrain: begin
        if (out_valid && out_ready && out_last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  // Cell (i,j): activation from the left, partial sum from above.
  always_comb begin
    for (int i = 0; i < K; i++) begin
      a_in[i][0] = sk_q[i][i];
      for (int j = 1; j < K; j++) a_in[i][j] = a_q[i][j-1];
    end
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) prod[i][j] = PW'(a_in[i][j]) * PW'(w_q[i][j]);
    end
    for (int j = 0; j < K; j++) p_d[0][j] = AW'(prod[0][j]);
    for (int i = 1; i < K; i++) begin
      for (int j = 0; j < K; j++) p_d[i][j] = AW'(prod[i][j]) + p_q[i-1][j];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      lst_q <= '0;
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K; j++) begin
          w_q[i][j]   <= '0;
          sk_q[i][j]  <= '0;
          a_q[i][j]   <= '0;
          p_q[i][j]   <= '0;
          dsk_q[i][j] <= '0;
        end
      end
    end else begin
      if (state_q == StLoad) begin
        for (int i = 0; i < K; i++) begin
          for (int j = 0; j < K; j++) w_q[i][j] <= w_data[(i*K+j)*DW +: DW];
        end
      end
      if (adv) begin
        vld_q <= {vld_q[2*K-1:0], accept};
        lst_q <= {lst_q[2*K-1:0], accept && in_last};
        // Row i is delayed by i extra stages; bubbles shift in zeros.
        for (int i = 0; i < K; i++) begin
          sk_q[i][0] <= accept ? in_data[i*DW +: DW] : '0;
          for (int s = 1; s < K; s++) begin
            if (s <= i) sk_q[i][s] <= sk_q[i][s-1];
          end
        end
        for (int i = 0; i < K; i++) begin
          for (int j = 0; j < K; j++) begin
            a_q[i][j] <= a_in[i][j];
            p_q[i][j] <= p_d[i][j];
          end
        end
        // Column j emerges j advances late, so it gets K-j stages, the last being the output.
        for (int j = 0; j < K; j++) begin
          dsk_q[j][0] <= p_q[K-1][j];
          for (int s = 1; s < K; s++) begin
            if (s < K - j) dsk_q[j][s] <= dsk_q[j][s-1];
          end
        end
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int j = 0; j < K; j++) out_data[j*AW +: AW] = dsk_q[j][K-1-j];
  end

endmodule

// File: tb/tb_systolic_mm.sv
// Self-checking bench for systolic_mm: a K=2 instance for exact-timing corner cases
// and a K=4 instance for table, stall, bubble and reset sequences.
module tb_systolic_mm;
  localparam int DW = 8;
  localparam int AW = 24;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk) cyc++;

  // K=2 instance
  logic            w_valid2, w_ready2, in_valid2, in_ready2, in_last2;
  logic            out_valid2, out_ready2, out_last2, busy2;
  logic [4*DW-1:0] w_data2;
  logic [2*DW-1:0] in_data2;
  logic [2*AW-1:0] out_data2;

  // K=4 instance
  logic             w_valid4, w_ready4, in_valid4, in_ready4, in_last4;
  logic             out_valid4, out_ready4, out_last4, busy4;
  logic [16*DW-1:0] w_data4;
  logic [4*DW-1:0]  in_data4;
  logic [4*AW-1:0]  out_data4;

  systolic_mm #(.K(2), .DW(DW), .AW(AW)) u_dut2 (
    .clk(clk), .rst(rst), .w_valid(w_valid2), .w_ready(w_ready2), .w_data(w_data2),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2), .in_last(in_last2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .out_last(out_last2), .busy(busy2)
  );

  systolic_mm #(.K(4), .DW(DW), .AW(AW)) u_dut4 (
    .clk(clk), .rst(rst), .w_valid(w_valid4), .w_ready(w_ready4), .w_data(w_data4),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4), .in_last(in_last4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
    .out_last(out_last4), .busy(busy4)
  );

  typedef struct packed {
    logic [3:0][DW-1:0] x;
    logic               last;
    logic [3:0][AW-1:0] y;
  } vec_t;

  vec_t tbl [8];

  task automatic check_int(input string name, input logic signed [63:0] act,
                           input logic signed [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  task automatic check_bits(input string name, input logic [127:0] act, input logic [127:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input int x0, input int x1, input int x2, input int x3,
                              input bit last, input int y0, input int y1, input int y2,
                              input int y3);
    vec_t v;
    v.x[0] = DW'(x0); v.x[1] = DW'(x1); v.x[2] = DW'(x2); v.x[3] = DW'(x3);
    v.last = last;
    v.y[0] = AW'(y0); v.y[1] = AW'(y1); v.y[2] = AW'(y2); v.y[3] = AW'(y3);
    return v;
  endfunction

  function automatic logic [4*AW-1:0] model4(input logic [4*DW-1:0] x,
                                             input logic [16*DW-1:0] w);
    logic [4*AW-1:0]      y;
    logic signed [AW-1:0] s;
    y = '0;
    for (int j = 0; j < 4; j++) begin
      s = '0;
      for (int i = 0; i < 4; i++)
        s = s + AW'($signed(x[i*DW +: DW])) * AW'($signed(w[(i*4+j)*DW +: DW]));
      y[j*AW +: AW] = s;
    end
    return y;
  endfunction

  // K=4 monitor: records accepted vectors and consumed results, checks stall behaviour.
  logic [4*DW-1:0] acc_q[$];
  logic [4*AW-1:0] got_q[$];
  logic            got_last_q[$];
  int              got_cyc_q[$];
  logic            hold_v = 1'b0;
  logic            hold_l;
  logic [4*AW-1:0] hold_d;

  always @(negedge clk) begin
    if (!rst) begin
      hold_v = 1'b0;
    end else begin
      if (in_valid4 && in_ready4) acc_q.push_back(in_data4);
      if (out_valid4 && out_ready4) begin
        got_q.push_back(out_data4);
        got_last_q.push_back(out_last4);
        got_cyc_q.push_back(cyc);
      end
      if (out_valid4 && !out_ready4) begin
        check_int("stall_in_ready", in_ready4, 0);
        if (hold_v) begin
          check_bits("stall_data", out_data4, hold_d);
          check_int("stall_last", out_last4, hold_l);
        end
        hold_v = 1'b1;
        hold_d = out_data4;
        hold_l = out_last4;
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  bit stall_en = 1'b0;
  always @(posedge clk) begin
    #1;
    out_ready4 = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  task automatic clear_q();
    acc_q.delete(); got_q.delete(); got_last_q.delete(); got_cyc_q.delete();
  endtask

  task automatic load2(input logic [4*DW-1:0] w);
    int t = 0;
    w_data2 = w; w_valid2 = 1'b1;
    @(negedge clk);
    while (!w_ready2 && t < 50) begin @(negedge clk); t++; end
    check_int("k2_w_ready", w_ready2, 1);
    @(posedge clk); #1 w_valid2 = 1'b0;
  endtask

  task automatic send2(input logic [2*DW-1:0] x, input logic last);
    int t = 0;
    in_data2 = x; in_last2 = last; in_valid2 = 1'b1;
    @(negedge clk);
    while (!in_ready2 && t < 50) begin @(negedge clk); t++; end
    check_int("k2_in_ready", in_ready2, 1);
    @(posedge clk); #1 in_valid2 = 1'b0; in_last2 = 1'b0;
  endtask

  task automatic wait_out2();
    int t = 0;
    @(negedge clk);
    while (!out_valid2 && t < 50) begin @(negedge clk); t++; end
    check_int("k2_out_valid", out_valid2, 1);
  endtask

  task automatic load4(input logic [16*DW-1:0] w);
    int t = 0;
    w_data4 = w; w_valid4 = 1'b1;
    @(negedge clk);
    while (!w_ready4 && t < 50) begin @(negedge clk); t++; end
    check_int("k4_w_ready", w_ready4, 1);
    @(posedge clk); #1 w_valid4 = 1'b0;
  endtask

  task automatic send4(input logic [4*DW-1:0] x, input logic last);
    int t = 0;
    in_data4 = x; in_last4 = last; in_valid4 = 1'b1;
    @(negedge clk);
    while (!in_ready4 && t < 300) begin @(negedge clk); t++; end
    check_int("k4_in_ready", in_ready4, 1);
    @(posedge clk); #1 in_valid4 = 1'b0; in_last4 = 1'b0;
  endtask

  task automatic wait_idle4();
    int t = 0;
    while (busy4 && t < 1000) begin @(negedge clk); t++; end
    check_int("k4_idle", busy4, 0);
    @(posedge clk); #1;
  endtask

  task automatic check_stream(input string tag, input int n, input logic [16*DW-1:0] w);
    check_int({tag, "_acc_count"}, acc_q.size(), n);
    check_int({tag, "_res_count"}, got_q.size(), n);
    for (int k = 0; k < n; k++) begin
      if (k < got_q.size() && k < acc_q.size()) begin
        check_bits($sformatf("%s_res%0d", tag, k), got_q[k], model4(acc_q[k], w));
        check_int($sformatf("%s_last%0d", tag, k), got_last_q[k], (k == n - 1));
      end
    end
  endtask

  initial begin
    logic [16*DW-1:0] w_ramp, w_rnd;
    logic [4*AW-1:0]  g;

    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [16*DW-1:0] w_ramp, w_rnd;
    logic [4*AW-1:0]  g;

    w_valid2 = 0; in_valid2 = 0; in_last2 = 0; out_ready2 = 1; w_data2 = '0; in_data2 = '0;
    w_valid4 = 0; in_valid4 = 0; in_last4 = 0; w_data4 = '0; in_data4 = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) w_ramp[(i*4+j)*DW +: DW] = DW'(i + j);
    // y[j] = T + j*S with S = sum x[i], T = sum i*x[i] for W[i][j] = i+j.
    tbl[0] = mk(1, 2, 3, 4, 0, 20, 30, 40, 50);
    tbl[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2] = mk(-1, -1, -1, -1, 0, -6, -10, -14, -18);
    tbl[3] = mk(127, 127, 127, 127, 0, 762, 1270, 1778, 2286);
    tbl[4] = mk(-128, -128, -128, -128, 0, -768, -1280, -1792, -2304);
    tbl[5] = mk(5, -3, 0, 2, 0, 3, 7, 11, 15);
    tbl[6] = mk(10, 0, 0, 0, 0, 0, 10, 20, 30);
    tbl[7] = mk(0, 0, 0, -7, 1, -21, -28, -35, -42);

    repeat (2) @(posedge clk);
    #1;
    check_int("rst_out_valid", out_valid4, 0);
    check_int("rst_out_last", out_last4, 0);
    check_bits("rst_out_data", out_data4, '0);
    check_int("rst_busy", busy4, 0);
    check_int("rst_w_ready", w_ready4, 1);
    check_int("rst_in_ready", in_ready4, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // K=2 identity, single-vector batch, exact latency of 2K edges.
    load2({8'sd1, 8'sd0, 8'sd0, 8'sd1});
    send2({-8'sd5, 8'sd3}, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      check_int($sformatf("k2_lat_c%0d", c), out_valid2, (c == 4));
    end
    check_int("k2_id_y0", $signed(out_data2[0 +: AW]), 3);
    check_int("k2_id_y1", $signed(out_data2[AW +: AW]), -5);
    check_int("k2_id_last", out_last2, 1);
    @(posedge clk); #1;
    check_int("k2_id_busy", busy2, 0);
    check_int("k2_id_w_ready", w_ready2, 1);
    check_int("k2_id_no_dup", out_valid2, 0);

    // K=2 extreme operands.
    load2({4{8'h80}});
    send2({2{8'h80}}, 1'b1);
    wait_out2();
    check_int("k2_neg_y0", $signed(out_data2[0 +: AW]), 32768);
    check_int("k2_neg_y1", $signed(out_data2[AW +: AW]), 32768);
    check_int("k2_neg_last", out_last2, 1);
    @(posedge clk); #1;
    check_int("k2_neg_busy", busy2, 0);
    load2({4{8'h7f}});
    send2({2{8'h7f}}, 1'b1);
    wait_out2();
    check_int("k2_pos_y0", $signed(out_data2[0 +: AW]), 32258);
    check_int("k2_pos_y1", $signed(out_data2[AW +: AW]), 32258);
    @(posedge clk); #1;

    // K=4 table: 8 back-to-back vectors, one result per cycle.
    clear_q();
    load4(w_ramp);
    for (int k = 0; k < 8; k++) send4(tbl[k].x, tbl[k].last);
    wait_idle4();
    check_int("tbl_count", got_q.size(), 8);
    for (int k = 0; k < 8; k++) begin
      if (k < got_q.size()) begin
        g = got_q[k];
        for (int j = 0; j < 4; j++)
          check_int($sformatf("tbl%0d_y%0d", k, j), $signed(g[j*AW +: AW]),
                    $signed(tbl[k].y[j]));
        check_int($sformatf("tbl%0d_last", k), got_last_q[k], tbl[k].last);
        if (k > 0) check_int($sformatf("tbl%0d_gap", k), got_cyc_q[k] - got_cyc_q[k-1], 1);
      end
    end

    // Random output back-pressure over 16 vectors.
    clear_q();
    stall_en = 1'b1;
    load4(w_ramp);
    for (int k = 0; k < 16; k++) send4($urandom(), (k == 15));
    wait_idle4();
    stall_en = 1'b0;
    check_stream("stall", 16, w_ramp);

    // Input bubble every third cycle.
    for (int n = 0; n < 4; n++) w_rnd[n*32 +: 32] = $urandom();
    clear_q();
    load4(w_rnd);
    for (int k = 0; k < 12; k++) begin
      send4($urandom(), (k == 11));
      if (k % 2 == 1 && k != 11) begin @(posedge clk); #1; end
    end
    wait_idle4();
    check_stream("bubble", 12, w_rnd);

    // Reset with three results in flight.
    clear_q();
    load4(w_ramp);
    for (int k = 0; k < 3; k++) send4($urandom(), 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    #2;
    check_int("mid_rst_out_valid", out_valid4, 0);
    check_bits("mid_rst_out_data", out_data4, '0);
    check_int("mid_rst_out_last", out_last4, 0);
    check_int("mid_rst_busy", busy4, 0);
    check_int("mid_rst_w_ready", w_ready4, 1);
    check_int("mid_rst_in_ready", in_ready4, 0);
    @(posedge clk); #1 rst = 1'b1;
    clear_q();
    repeat (20) @(posedge clk);
    #1;
    check_int("post_rst_no_results", got_q.size(), 0);
    check_int("post_rst_busy", busy4, 0);
    for (int n = 0; n < 4; n++) w_rnd[n*32 +: 32] = $urandom();
    load4(w_rnd);
    for (int k = 0; k < 4; k++) send4($urandom(), (k == 3));
    wait_idle4();
    check_stream("post_rst", 4, w_rnd);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
